i2c_reg_seq: RTL
================

Name: i2c_reg_seq

Overview:
- Register-level transaction sequencer directly upstream of the byte-level I2C master in the wb_i2c path.
- Accepts one host command (register write of 1 byte, or register read of 1-4 bytes) and drives the master's ena/rw/addr/data_wr handshake byte by byte.
- Collects the master's data_rd and ack_error, then returns a done pulse with read data and error status.
- Lets the Wishbone wrapper and feeder control logic issue whole sensor/RTC register accesses without tracking master byte timing.

Parameters:
- TIMEOUT_CYC, 200000: max clk cycles without any m_busy edge before abort (≥ 2 I2C byte times at 100 kHz / 50 MHz).
- TCW, 18: timeout counter width; must satisfy 2^TCW > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle command strobe; ignored while busy=1.
- rw  in  1  0 = register write, 1 = register read.
- dev_addr  in  7  7-bit slave address.
- reg_addr  in  8  register pointer byte.
- wdata  in  8  write data byte.
- nbytes_m1  in  2  read byte count minus 1 (0..3 → 1..4 bytes); ignored for writes.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- error  out  2  bit0 = slave NACK seen, bit1 = timeout; valid with done, held until next start.
- rdata  out  32  read bytes, MSB-first, right-justified; cleared at start.
- m_ena  out  1  to master ena.
- m_rw  out  1  to master rw.
- m_addr  out  7  to master addr.
- m_data_wr  out  8  to master data_wr.
- m_busy  in  1  from master busy.
- m_ack_error  in  1  from master ack_error.
- m_data_rd  in  8  from master data_rd.

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; counters 0; m_busy_q = 1 (the master reports busy during its own reset).
- Edge detect:
  - m_busy_q registers m_busy each clk.
  - rise = m_busy & ~m_busy_q; fall = ~m_busy & m_busy_q.
- IDLE:
  - On start & ~m_busy, latch inputs; set busy=1, rdata=0, error=0, rcnt=0.
  - Drive m_ena=1, m_addr=dev_addr, m_rw=0, m_data_wr=reg_addr.
  - Go REG.
  - start while m_busy=1 is dropped (no done).
- REG, on rise (master accepted the reg_addr byte):
  - Write command: m_data_wr=wdata; go WDATA.
  - Read command: m_rw=1, requesting a repeated start plus read; go RD.
- WDATA, on rise: m_ena=0; go FIN.
- RD:
  - On each rise: rcnt increments; when rcnt reaches nbytes_m1+1, set m_ena=0.
  - The first rise in RD is the read command's acceptance, so exactly nbytes_m1+1 read bytes follow.
  - On each fall, once rcnt≥1 and the byte is not yet captured: rdata = {rdata[23:0], m_data_rd}.
  - After nbytes_m1+1 captures, go FIN.
- FIN, when m_busy=0 (stop sent):
  - done=1 for one cycle; error[0] = m_ack_error sampled that cycle.
  - busy=0; go IDLE.
- Timeout:
  - tcnt clears on start and on any rise/fall; otherwise it increments while not IDLE.
  - At tcnt == TIMEOUT_CYC-1: m_ena=0, error[1]=1, go FIN. FIN waits for m_busy=0 with the counter still running.
  - A second expiry in FIN forces done anyway.
- NACK does not abort early; the master completes the byte sequence and the NACK is reported at done.
- m_addr, m_rw and m_data_wr hold their values between updates.
- done and start in the same cycle: start is accepted on the next IDLE cycle only.
- Reset mid-command: immediate return to IDLE, no done.

Test Plan:
- Write: dev 0x68, reg 0x0E, wdata 0x1C with master+slave model ACKing → m_data_wr sequence 0x0E, 0x1C; m_rw stays 0; one done; error=00; busy high throughout.
- Read 2 bytes: reg 0x00, nbytes_m1=1, slave returns 0x12, 0x34 → m_rw 0→1 after the first rise; rdata=0x00001234; m_ena drops after the 3rd busy rise; done; error=00.
- Read 4 bytes (nbytes_m1=3): bytes 0xDE, 0xAD, 0xBE, 0xEF → rdata=0xDEADBEEF; exactly 4 captures.
- Absent slave (NACK on the address) → done with error=01; rdata=0 for a read.
- Slave model holding scl low forever → after TIMEOUT_CYC cycles m_ena=0, error[1]=1, done once.
- start asserted while busy, and reset asserted mid-read → second start ignored; after reset all outputs 0, and a following command completes normally.

Source files
------------

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq
// Register-level transaction sequencer that sits in front of a byte-level
// I2C master. One host command (1-byte register write, or 1..4-byte register
// read) is expanded into the master's ena/rw/addr/data_wr byte handshake.
// The master's busy edges mark progress: a rising edge means the byte
// command presented on the master inputs was accepted, and a falling edge
// means a byte finished (data_rd valid for reads). The read data and the
// NACK/timeout status are returned together with a one-cycle done pulse.
module i2c_reg_seq #(
    parameter int TIMEOUT_CYC = 200000,
    parameter int TCW         = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  wdata,
    input  logic [1:0]  nbytes_m1,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [31:0] rdata,
    output logic        m_ena,
    output logic        m_rw,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_data_wr,
    input  logic        m_busy,
    input  logic        m_ack_error,
    input  logic [7:0]  m_data_rd
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REG   = 3'd1,
        S_WDATA = 3'd2,
        S_RD    = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    // Last value of the stall counter before an abort is forced.
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYC - 1);

    state_t         state_reg, state_next;
    logic           m_busy_q_reg;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [1:0]     error_reg, error_next;
    logic [31:0]    rdata_reg, rdata_next;
    logic           m_ena_reg, m_ena_next;
    logic           m_rw_reg, m_rw_next;
    logic [6:0]     m_addr_reg, m_addr_next;
    logic [7:0]     m_data_wr_reg, m_data_wr_next;

    // Latched command fields, stable for the whole transaction.
    logic           cmd_rw_reg, cmd_rw_next;
    logic [7:0]     cmd_wdata_reg, cmd_wdata_next;
    logic [1:0]     cmd_nbm1_reg, cmd_nbm1_next;

    // rcnt counts accepted commands in RD (the first is the read request
    // itself), ccnt counts bytes already shifted into rdata.
    logic [2:0]     rcnt_reg, rcnt_next;
    logic [2:0]     ccnt_reg, ccnt_next;
    logic [TCW-1:0] tcnt_reg, tcnt_next;

    logic           busy_rise;
    logic           busy_fall;
    logic           busy_edge;
    logic           tc_expired;
    logic [2:0]     read_total;

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign rdata     = rdata_reg;
    assign m_ena     = m_ena_reg;
    assign m_rw      = m_rw_reg;
    assign m_addr    = m_addr_reg;
    assign m_data_wr = m_data_wr_reg;

    // Master busy edge detection and the derived progress/timeout qualifiers.
    always_comb begin
        busy_rise  = m_busy & ~m_busy_q_reg;
        busy_fall  = ~m_busy & m_busy_q_reg;
        busy_edge  = busy_rise | busy_fall;
        // A busy edge in the same cycle counts as progress and wins over expiry.
        tc_expired = (state_reg != S_IDLE) && !busy_edge && (tcnt_reg == TC_LAST);
        read_total = {1'b0, cmd_nbm1_reg} + 3'd1;
    end

    // Stall counter: held at zero in IDLE, restarted by any busy edge and by
    // its own expiry so that FIN gets a second full window before forcing done.
    always_comb begin
        tcnt_next = tcnt_reg + TCW'(1);
        if ((state_reg == S_IDLE) || busy_edge || tc_expired) begin
            tcnt_next = '0;
        end
    end

    // Sequencer next-state and output logic.
    always_comb begin
        state_next     = state_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        error_next     = error_reg;
        rdata_next     = rdata_reg;
        m_ena_next     = m_ena_reg;
        m_rw_next      = m_rw_reg;
        m_addr_next    = m_addr_reg;
        m_data_wr_next = m_data_wr_reg;
        cmd_rw_next    = cmd_rw_reg;
        cmd_wdata_next = cmd_wdata_reg;
        cmd_nbm1_next  = cmd_nbm1_reg;
        rcnt_next      = rcnt_reg;
        ccnt_next      = ccnt_reg;

        case (state_reg)
            S_IDLE: begin
                // A start that arrives while the master is still busy is dropped.
                if (start && !m_busy) begin
                    cmd_rw_next    = rw;
                    cmd_wdata_next = wdata;
                    cmd_nbm1_next  = nbytes_m1;
                    busy_next      = 1'b1;
                    rdata_next     = '0;
                    error_next     = '0;
                    rcnt_next      = '0;
                    ccnt_next      = '0;
                    // Every command opens with a write of the register pointer.
                    m_ena_next     = 1'b1;
                    m_addr_next    = dev_addr;
                    m_rw_next      = 1'b0;
                    m_data_wr_next = reg_addr;
                    state_next     = S_REG;
                end
            end

            S_REG: begin
                if (tc_expired) begin
                    m_ena_next    = 1'b0;
                    error_next[1] = 1'b1;
                    state_next    = S_FIN;
                end else if (busy_rise) begin
                    // Pointer byte accepted: queue the next byte command now so
                    // it is stable before the master looks at ena again.
                    if (cmd_rw_reg) begin
                        m_rw_next  = 1'b1;
                        state_next = S_RD;
                    end else begin
                        m_data_wr_next = cmd_wdata_reg;
                        state_next     = S_WDATA;
                    end
                end
            end

            S_WDATA: begin
                if (tc_expired) begin
                    m_ena_next    = 1'b0;
                    error_next[1] = 1'b1;
                    state_next    = S_FIN;
                end else if (busy_rise) begin
                    // Data byte accepted: dropping ena makes the master stop after it.
                    m_ena_next = 1'b0;
                    state_next = S_FIN;
                end
            end

            S_RD: begin
                if (tc_expired) begin
                    m_ena_next    = 1'b0;
                    error_next[1] = 1'b1;
                    state_next    = S_FIN;
                end else if (busy_rise) begin
                    rcnt_next = rcnt_reg + 3'd1;
                    // Once the last read byte is accepted, the master must stop after it.
                    if ((rcnt_reg + 3'd1) == read_total) begin
                        m_ena_next = 1'b0;
                    end
                end else if (busy_fall && (rcnt_reg != 3'd0) && (ccnt_reg < rcnt_reg)) begin
                    // The fall before the first read acceptance ends the pointer
                    // byte and carries no data, hence the rcnt guard.
                    rdata_next = {rdata_reg[23:0], m_data_rd};
                    ccnt_next  = ccnt_reg + 3'd1;
                    if ((ccnt_reg + 3'd1) == read_total) begin
                        state_next = S_FIN;
                    end
                end
            end

            S_FIN: begin
                // Wait for the stop condition; a further expiry releases the host anyway.
                if (!m_busy || tc_expired) begin
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    m_ena_next    = 1'b0;
                    error_next[0] = m_ack_error;
                    if (tc_expired) begin
                        error_next[1] = 1'b1;
                    end
                    state_next    = S_IDLE;
                end
            end

            default: begin
                m_ena_next = 1'b0;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; the master is assumed busy while reset is applied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            m_busy_q_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= '0;
            rdata_reg     <= '0;
            m_ena_reg     <= 1'b0;
            m_rw_reg      <= 1'b0;
            m_addr_reg    <= '0;
            m_data_wr_reg <= '0;
            cmd_rw_reg    <= 1'b0;
            cmd_wdata_reg <= '0;
            cmd_nbm1_reg  <= '0;
            rcnt_reg      <= '0;
            ccnt_reg      <= '0;
            tcnt_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            m_busy_q_reg  <= m_busy;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            rdata_reg     <= rdata_next;
            m_ena_reg     <= m_ena_next;
            m_rw_reg      <= m_rw_next;
            m_addr_reg    <= m_addr_next;
            m_data_wr_reg <= m_data_wr_next;
            cmd_rw_reg    <= cmd_rw_next;
            cmd_wdata_reg <= cmd_wdata_next;
            cmd_nbm1_reg  <= cmd_nbm1_next;
            rcnt_reg      <= rcnt_next;
            ccnt_reg      <= ccnt_next;
            tcnt_reg      <= tcnt_next;
        end
    end

endmodule
